// File: rtl/mac_acc_drain.sv
// Accumulates CHUNK_NUM signed MAC partials per dot product and buffers the
// finished results in a first-word-fall-through FIFO drained by valid/ready.
module mac_acc_drain #(
  parameter int IDATA_BIT  = 20,
  parameter int ACC_BIT    = 32,
  parameter int CHUNK_NUM  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [IDATA_BIT-1:0]          idata,
  input  logic                          idata_valid,
  input  logic                          acc_clr,
  output logic [ACC_BIT-1:0]            odata,
  output logic                          odata_valid,
  input  logic                          odata_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (CHUNK_NUM > 1) ? $clog2(CHUNK_NUM) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNK_NUM - 1);

  logic signed [IDATA_BIT-1:0] idata_s;
  logic signed [ACC_BIT-1:0]   idata_ext;
  logic signed [ACC_BIT-1:0]   acc;
  logic signed [ACC_BIT-1:0]   sum;
  logic [CNT_W-1:0]            chunk_cnt;

  logic [ACC_BIT-1:0] mem [FIFO_DEPTH];
  logic [ACC_BIT-1:0] last_head;
  logic [PTR_W:0]     wr_ptr;
  logic [PTR_W:0]     rd_ptr;
  logic [PTR_W-1:0]   wr_idx;
  logic [PTR_W-1:0]   rd_idx;

  logic full;
  logic push;
  logic pop;
  logic push_ok;
  logic drop;

  assign idata_s   = idata;
  assign idata_ext = ACC_BIT'(idata_s);
  assign sum       = acc + idata_ext;

  // Extra pointer MSB distinguishes full from empty without a separate counter.
  assign wr_idx      = wr_ptr[PTR_W-1:0];
  assign rd_idx      = rd_ptr[PTR_W-1:0];
  assign fifo_cnt    = wr_ptr - rd_ptr;
  assign odata_valid = (fifo_cnt != '0);
  assign full        = fifo_cnt[PTR_W];

  assign push    = idata_valid && !acc_clr && (chunk_cnt == LAST_CHUNK);
  assign pop     = odata_valid && odata_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  // When empty, keep presenting whatever was last at the head.
  assign odata = odata_valid ? mem[rd_idx] : last_head;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc       <= '0;
      chunk_cnt <= '0;
    end else if (acc_clr) begin
      acc       <= '0;
      chunk_cnt <= '0;
    end else if (idata_valid) begin
      if (chunk_cnt == LAST_CHUNK) begin
        acc       <= '0;
        chunk_cnt <= '0;
      end else begin
        acc       <= sum;
        chunk_cnt <= chunk_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (acc_clr) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_head <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_idx] <= sum;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        last_head <= mem[rd_idx];
        rd_ptr    <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_acc_drain.sv
// Randomized and directed bench for mac_acc_drain; a 32-bit and a 20-bit
// accumulator instance share stimulus and are checked against a queue model.
module tb_mac_acc_drain;

  localparam int CHUNK = 4;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rstn;
  logic [19:0] idata;
  logic        idata_valid;
  logic        acc_clr;
  logic        odata_ready;

  logic [31:0] odata;
  logic        odata_valid;
  logic [2:0]  fifo_cnt;
  logic        overflow;

  logic [19:0] odata20;
  logic        odata_valid20;
  logic [2:0]  fifo_cnt20;
  logic        overflow20;

  int errors = 0;
  int checks = 0;

  int macc = 0;
  int mcnt = 0;
  bit movf = 0;
  int q[$];

  mac_acc_drain #(.IDATA_BIT(20), .ACC_BIT(32), .CHUNK_NUM(CHUNK), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rstn(rstn), .idata(idata), .idata_valid(idata_valid), .acc_clr(acc_clr),
    .odata(odata), .odata_valid(odata_valid), .odata_ready(odata_ready),
    .fifo_cnt(fifo_cnt), .overflow(overflow)
  );

  mac_acc_drain #(.IDATA_BIT(20), .ACC_BIT(20), .CHUNK_NUM(CHUNK), .FIFO_DEPTH(DEPTH)) u_dut20 (
    .clk(clk), .rstn(rstn), .idata(idata), .idata_valid(idata_valid), .acc_clr(acc_clr),
    .odata(odata20), .odata_valid(odata_valid20), .odata_ready(odata_ready),
    .fifo_cnt(fifo_cnt20), .overflow(overflow20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int h;
    logic signed [19:0] h20;
    chk("valid", odata_valid, q.size() != 0);
    chk("cnt", fifo_cnt, q.size());
    chk("ovf", overflow, movf);
    chk("valid20", odata_valid20, q.size() != 0);
    chk("cnt20", fifo_cnt20, q.size());
    chk("ovf20", overflow20, movf);
    if (q.size() != 0) begin
      h   = q[0];
      h20 = h[19:0];
      chk("odata", $signed(odata), h);
      chk("odata20", $signed(odata20), h20);
    end
  endtask

  // One clock: drive inputs, advance the reference at the edge, then compare.
  task automatic cyc(input logic v, input int d, input logic clr, input logic rdy);
    logic signed [19:0] d20;
    bit pop;
    bit full;
    int s;
    d20         = 20'(d);
    idata       = d20;
    idata_valid = v;
    acc_clr     = clr;
    odata_ready = rdy;
    @(posedge clk);
    pop  = (q.size() != 0) && rdy;
    full = (q.size() == DEPTH);
    if (pop) void'(q.pop_front());
    if (clr) begin
      macc = 0;
      mcnt = 0;
      movf = 0;
    end else if (v) begin
      s = macc + int'(d20);
      if (mcnt == CHUNK - 1) begin
        if (!full || pop) q.push_back(s);
        else movf = 1;
        macc = 0;
        mcnt = 0;
      end else begin
        macc = s;
        mcnt++;
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    rstn        = 1'b1;
    idata       = '0;
    idata_valid = 1'b0;
    acc_clr     = 1'b0;
    odata_ready = 1'b0;
    #1 rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_odata", $signed(odata), 0);
    chk("rst_valid", odata_valid, 0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Basic dot product
    cyc(1, 100, 0, 1);
    cyc(1, -30, 0, 1);
    cyc(1, 7, 0, 1);
    cyc(1, 1, 0, 1);
    chk("dot78", $signed(odata), 78);
    cyc(0, 0, 0, 1);
    chk("drained", fifo_cnt, 0);

    // Sign extension of the most negative partial
    repeat (4) cyc(1, -524288, 0, 1);
    chk("sext_min", $signed(odata), -2097152);
    cyc(0, 0, 0, 1);

    // Wrap in the 20-bit accumulator instance
    cyc(1, 524287, 0, 1);
    cyc(1, 1, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    chk("wrap20", $signed(odata20), -524288);
    chk("nowrap32", $signed(odata), 524288);
    cyc(0, 0, 0, 1);

    // Fill under backpressure, then overflow on the fifth result
    for (int i = 0; i < 16; i++) cyc(1, $urandom_range(0, 2000) - 1000, 0, 0);
    chk("full_cnt", fifo_cnt, 4);
    for (int i = 0; i < 4; i++) cyc(1, $urandom_range(0, 2000) - 1000, 0, 0);
    chk("ovf_set", overflow, 1);
    repeat (5) cyc(0, 0, 0, 1);
    chk("ovf_sticky", overflow, 1);
    cyc(0, 0, 1, 1);
    chk("ovf_clr", overflow, 0);

    // Full FIFO with the final partial coinciding with a pop
    for (int i = 0; i < 16; i++) cyc(1, $urandom_range(0, 2000) - 1000, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, $urandom_range(0, 2000) - 1000, 0, 0);
    cyc(1, 55, 0, 1);
    chk("pushpop_cnt", fifo_cnt, 4);
    chk("pushpop_ovf", overflow, 0);
    repeat (5) cyc(0, 0, 0, 1);

    // Clear drops the in-flight partials including the coincident one
    cyc(1, 5, 0, 1);
    cyc(1, 6, 0, 1);
    cyc(1, 9, 1, 1);
    cyc(1, 1, 0, 1);
    cyc(1, 2, 0, 1);
    cyc(1, 3, 0, 1);
    cyc(1, 4, 0, 1);
    chk("clr_dot10", $signed(odata), 10);
    cyc(0, 0, 0, 1);

    // Asynchronous reset with two results buffered and a partial sum pending
    for (int i = 0; i < 10; i++) cyc(1, $urandom_range(0, 200), 0, 0);
    chk("pre_rst_cnt", fifo_cnt, 2);
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", odata_valid, 0);
    chk("arst_cnt", fifo_cnt, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_valid20", odata_valid20, 0);
    macc = 0;
    mcnt = 0;
    movf = 0;
    q.delete();
    @(negedge clk);
    rstn = 1'b1;
    cyc(1, 11, 0, 1);
    cyc(1, 22, 0, 1);
    cyc(1, 33, 0, 1);
    cyc(1, 44, 0, 1);
    chk("post_rst_dot", $signed(odata), 110);
    cyc(0, 0, 0, 1);

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, int'($urandom), $urandom_range(0, 40) == 0,
          $urandom_range(0, 2) != 0);
    end
    repeat (6) cyc(0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
